ppg_vshift_seq: RTL

Vertical-shift sequencer for the CCD programmable pulse generator. On a start request it emits a fixed 4-phase, 2-wire vertical transfer pattern for a programmed number of lines, with a programmable phase length and inter-line gap. Outputs `v1`/`v2` are registered logic-level clocks. Each one feeds the `cki` input of its own downstream DG412 deadtime driver, which adds break-before-make and the `arm` gating.

---
 rtl/ppg_vshift_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ppg_vshift_seq.sv
// Vertical-shift sequencer: emits the 4-phase (v1, v2) transfer pattern for a
// programmed number of lines, with programmable phase length and inter-line gap.
module ppg_vshift_seq #(
    parameter int CNT_W   = 10,
    parameter int LINES_W = 12
) (
    input  logic               clk_fast,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [LINES_W-1:0] nlines,
    input  logic [CNT_W-1:0]   t_ph,
    input  logic [CNT_W-1:0]   t_gap,
    output logic               v1,
    output logic               v2,
    output logic               busy,
    output logic               done,
    output logic [LINES_W-1:0] lines_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PA,
        S_PB,
        S_PC,
        S_PD,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINES_W-1:0] r_lines;
    logic [CNT_W-1:0]   r_tph;
    logic [CNT_W-1:0]   r_tgap;
    logic               r_v1;
    logic               r_v2;
    logic               r_done;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [LINES_W-1:0] w_lines_next;
    logic [CNT_W-1:0]   w_tph_next;
    logic [CNT_W-1:0]   w_tgap_next;
    logic               w_v1_next;
    logic               w_v2_next;
    logic               w_done_next;
    logic [CNT_W-1:0]   w_tph_in;
    logic [CNT_W-1:0]   w_ph_reload;

    // A programmed phase length of 0 behaves as 1 cycle.
    assign w_tph_in    = (t_ph == '0) ? CNT_W'(1) : t_ph;
    assign w_ph_reload = r_tph - CNT_W'(1);

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lines <= '0;
            r_tph   <= '0;
            r_tgap  <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_lines <= w_lines_next;
            r_tph   <= w_tph_next;
            r_tgap  <= w_tgap_next;
            r_v1    <= w_v1_next;
            r_v2    <= w_v2_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_lines_next = r_lines;
        w_tph_next   = r_tph;
        w_tgap_next  = r_tgap;
        w_done_next  = 1'b0;

        if (r_state == S_IDLE) begin
            if (start && !abort) begin
                w_tph_next   = w_tph_in;
                w_tgap_next  = t_gap;
                w_lines_next = nlines;
                if (nlines != '0) begin
                    w_state_next = S_PA;
                    w_cnt_next   = w_tph_in - CNT_W'(1);
                end else begin
                    w_done_next = 1'b1;
                end
            end
        end else if (abort) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_lines_next = '0;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
            w_cnt_next = w_ph_reload;
            case (r_state)
                S_PA:  w_state_next = S_PB;
                S_PB:  w_state_next = S_PC;
                S_PC:  w_state_next = S_PD;
                S_PD: begin
                    w_lines_next = r_lines - LINES_W'(1);
                    if (r_lines == LINES_W'(1)) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                        w_done_next  = 1'b1;
                    end else if (r_tgap != '0) begin
                        w_state_next = S_GAP;
                        w_cnt_next   = r_tgap - CNT_W'(1);
                    end else begin
                        w_state_next = S_PA;
                    end
                end
                S_GAP: w_state_next = S_PA;
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Levels decoded from the next state so v1/v2 move on the same edge as the state.
    always_comb begin
        w_v1_next = 1'b0;
        w_v2_next = 1'b1;
        case (w_state_next)
            S_PA: begin
                w_v1_next = 1'b1;
                w_v2_next = 1'b1;
            end
            S_PB: begin
                w_v1_next = 1'b1;
                w_v2_next = 1'b0;
            end
            S_PC: begin
                w_v1_next = 1'b0;
                w_v2_next = 1'b0;
            end
            default: begin
                w_v1_next = 1'b0;
                w_v2_next = 1'b1;
            end
        endcase
    end

    assign v1         = r_v1;
    assign v2         = r_v2;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign lines_left = r_lines;

endmodule
